xy_diag_write_arb: RTL and testbench
====================================

Name: xy_diag_write_arb

Overview:
- Per-channel arbiter in front of a diagonal xy_switch block (BLOCK_ID == ROW_ID).
- The switch's diagonal write and read paths take one command per channel per cycle and have no backpressure.
- This block shares each channel's single east-bound slot between the west, north and south write requesters and the west read requester.
- Output is one registered command per channel per cycle; read and write are mutually exclusive on a channel.

Parameters:
CH_NUM, 8, number of independent channels
STARVE_LIMIT, 4, consecutive cycles a pending write may lose to reads before it is forced through
CNT_W, 3, width of the starvation counter (must hold STARVE_LIMIT)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
west_wr_vld  in  CH_NUM  west write request per channel
west_wr_pld  in  write_ram_cmd_t[CH_NUM]  west write payload
west_wr_rdy  out  CH_NUM  west write grant (combinational)
north_wr_vld/north_wr_pld/north_wr_rdy  same as west, north source
south_wr_vld/south_wr_pld/south_wr_rdy  same as west, south source
west_rd_vld  in  CH_NUM  read request per channel
west_rd_pld  in  arb_out_req_t[CH_NUM]  read payload
west_rd_rdy  out  CH_NUM  read grant (combinational)
east_write_cmd_out_vld  out  CH_NUM  registered write command to switch
east_write_cmd_out_pld  out  write_ram_cmd_t[CH_NUM]  registered write payload
east_read_cmd_out_vld  out  CH_NUM  registered read command to switch
east_read_cmd_out_pld  out  arb_out_req_t[CH_NUM]  registered read payload
starve_evt  out  CH_NUM  1-cycle pulse when a forced write grant occurs

Behaviour:
- Channels are fully independent; all rules below apply per channel i.
- Handshake: a transfer occurs when vld && rdy in the same cycle. Requesters hold vld and pld stable until rdy. rdy depends on the current vld inputs and state only; there is no combinational path from payload to rdy.
- Slot decision each cycle, in priority order:
  (a) No write vld: read granted if rd_vld.
  (b) Write vld and no rd_vld: write granted.
  (c) Both present and starve_cnt < STARVE_LIMIT: read granted, starve_cnt += 1.
  (d) Both present and starve_cnt == STARVE_LIMIT: write granted, read rdy = 0, starve_evt = 1 (combinational, same cycle).
- Write source selection: round-robin over W→N→S starting at rr_ptr. On a write grant, rr_ptr moves to the source after the winner (S wraps to W). rr_ptr is unchanged on read grants or idle cycles.
- starve_cnt:
  - Clears to 0 on any write grant.
  - Holds when no write is pending.
  - Saturates at STARVE_LIMIT.
- At most one rdy (across all four requesters) is high per channel per cycle.
- Latency: 1 cycle. Grant in cycle N produces out_vld = 1 with the granted pld in cycle N+1. Otherwise out_vld = 0 in N+1.
- out_pld registers load only on a grant and hold their value otherwise.
- east_write_cmd_out_vld[i] & east_read_cmd_out_vld[i] is never 1.
- Back-to-back grants every cycle are supported; full throughput is 1 command per channel per cycle.
- Reset, synchronous, when rst = 1 at a clk edge:
  - All out_vld = 0, all out_pld = 0, starve_evt = 0.
  - rr_ptr = W, starve_cnt = 0.
  - All rdy forced to 0 while rst is high.
  - Commands granted in the reset cycle are dropped. Requesters re-present after reset.
- STARVE_LIMIT = 0: writes always win over reads (read starvation is permitted; documented configuration).

Decomposition:
- vector_cache_pkg holds write_ram_cmd_t and arb_out_req_t (existing types).
- Add to vector_cache_pkg:
  - typedef xy_src_e {XY_SRC_W = 0, XY_SRC_N = 1, XY_SRC_S = 2}
  - localparam XY_STARVE_LIMIT_DFLT = 4
- Sub-module rr_arb3: 3-way round-robin arbiter.
  - Inputs: req[2:0], ptr, en.
  - Outputs: one-hot gnt[2:0], next_ptr.
  - Combinational; the pointer register lives in the parent.
- Parent generates CH_NUM instances of the channel slice.

Test Plan:
- Only west_wr_vld[0] = 1, pld.addr = 0x10 for 1 cycle → west_wr_rdy[0] = 1 same cycle; east_write_cmd_out_vld[0] = 1 with addr 0x10 next cycle, then 0; other channels silent.
- W, N, S all vld on ch3 for 6 cycles, rr_ptr = W after reset → grant order W, N, S, W, N, S; six consecutive east_write_cmd_out_vld[3] pulses with matching plds.
- rd_vld[1] held high and north_wr_vld[1] high from cycle 0, STARVE_LIMIT = 4 → reads granted cycles 0–3; cycle 4 north granted, west_rd_rdy[1] = 0, starve_evt[1] = 1; cycle 5 read resumes, starve_cnt = 1.
- Every channel gets rd_vld plus a write each cycle for 100 random cycles → assertion: read out_vld and write out_vld never both high on the same channel; at most one rdy per channel per cycle.
- rst asserted in the same cycle as south_wr_vld[2] = 1 → south_wr_rdy[2] = 0; all outputs 0 next cycle; after rst drops, south is granted first time it is presented with rr_ptr = W and no other requests.
- All 8 channels with a write every cycle for 16 cycles → 16 out_vld pulses per channel, no bubbles, no cross-channel payload mixing.

Source files
------------

// File: rtl/vector_cache_pkg.sv
// rtl/vector_cache_pkg.sv - shared command types and source encoding for the vector cache xy switch
package vector_cache_pkg;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } write_ram_cmd_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  id;
    } arb_out_req_t;

    typedef enum logic [1:0] {
        XY_SRC_W = 2'd0,
        XY_SRC_N = 2'd1,
        XY_SRC_S = 2'd2
    } xy_src_e;

    localparam int XY_STARVE_LIMIT_DFLT = 4;

    // Round-robin successor: W -> N -> S -> W
    function automatic xy_src_e xy_src_next(input xy_src_e s);
        case (s)
            XY_SRC_W: return XY_SRC_N;
            XY_SRC_N: return XY_SRC_S;
            default:  return XY_SRC_W;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// rtl/rr_arb3.sv - combinational 3-way round-robin arbiter, pointer register held by the parent
module rr_arb3
    import vector_cache_pkg::*;
(
    input  logic    [2:0] req,
    input  xy_src_e       ptr,
    input  logic          en,
    output logic    [2:0] gnt,
    output xy_src_e       next_ptr
);

    xy_src_e w_c0;
    xy_src_e w_c1;
    xy_src_e w_c2;
    xy_src_e w_win;
    logic    w_found;

    always_comb begin
        w_c0    = ptr;
        w_c1    = xy_src_next(w_c0);
        w_c2    = xy_src_next(w_c1);
        w_win   = ptr;
        w_found = 1'b0;
        if (req[w_c0]) begin
            w_win   = w_c0;
            w_found = 1'b1;
        end else if (req[w_c1]) begin
            w_win   = w_c1;
            w_found = 1'b1;
        end else if (req[w_c2]) begin
            w_win   = w_c2;
            w_found = 1'b1;
        end

        gnt      = 3'b000;
        next_ptr = ptr;
        if (en && w_found) begin
            gnt[w_win] = 1'b1;
            next_ptr   = xy_src_next(w_win);
        end
    end

endmodule

// File: rtl/xy_diag_write_arb.sv
// rtl/xy_diag_write_arb.sv - per-channel slot arbiter sharing the diagonal east slot between W/N/S writes and W reads
module xy_diag_write_arb
    import vector_cache_pkg::*;
#(
    parameter int CH_NUM       = 8,
    parameter int STARVE_LIMIT = XY_STARVE_LIMIT_DFLT,
    parameter int CNT_W        = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic           [CH_NUM-1:0] west_wr_vld,
    input  write_ram_cmd_t [CH_NUM-1:0] west_wr_pld,
    output logic           [CH_NUM-1:0] west_wr_rdy,
    input  logic           [CH_NUM-1:0] north_wr_vld,
    input  write_ram_cmd_t [CH_NUM-1:0] north_wr_pld,
    output logic           [CH_NUM-1:0] north_wr_rdy,
    input  logic           [CH_NUM-1:0] south_wr_vld,
    input  write_ram_cmd_t [CH_NUM-1:0] south_wr_pld,
    output logic           [CH_NUM-1:0] south_wr_rdy,
    input  logic           [CH_NUM-1:0] west_rd_vld,
    input  arb_out_req_t   [CH_NUM-1:0] west_rd_pld,
    output logic           [CH_NUM-1:0] west_rd_rdy,
    output logic           [CH_NUM-1:0] east_write_cmd_out_vld,
    output write_ram_cmd_t [CH_NUM-1:0] east_write_cmd_out_pld,
    output logic           [CH_NUM-1:0] east_read_cmd_out_vld,
    output arb_out_req_t   [CH_NUM-1:0] east_read_cmd_out_pld,
    output logic           [CH_NUM-1:0] starve_evt
);

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        logic [2:0]       w_wr_req;
        logic             w_any_wr;
        logic             w_rd_req;
        logic             w_force;
        logic             w_wr_grant;
        logic             w_rd_grant;
        logic [2:0]       w_gnt;
        xy_src_e          w_next_ptr;
        write_ram_cmd_t   w_wr_pld;

        xy_src_e          r_ptr;
        logic [CNT_W-1:0] r_cnt;
        logic             r_wr_vld;
        logic             r_rd_vld;
        write_ram_cmd_t   r_wr_pld;
        arb_out_req_t     r_rd_pld;

        assign w_wr_req = {south_wr_vld[g], north_wr_vld[g], west_wr_vld[g]};
        assign w_any_wr = |w_wr_req;
        assign w_rd_req = west_rd_vld[g];

        // A write that has already lost STARVE_LIMIT times in a row takes the slot from the read
        assign w_force    = w_any_wr && w_rd_req && (r_cnt == CNT_W'(STARVE_LIMIT));
        assign w_wr_grant = !rst && w_any_wr && (!w_rd_req || w_force);
        assign w_rd_grant = !rst && w_rd_req && !w_force;

        rr_arb3 u_rr_arb3 (
            .req      (w_wr_req),
            .ptr      (r_ptr),
            .en       (w_wr_grant),
            .gnt      (w_gnt),
            .next_ptr (w_next_ptr)
        );

        always_comb begin
            w_wr_pld = west_wr_pld[g];
            if (w_gnt[1]) begin
                w_wr_pld = north_wr_pld[g];
            end else if (w_gnt[2]) begin
                w_wr_pld = south_wr_pld[g];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ptr    <= XY_SRC_W;
                r_cnt    <= '0;
                r_wr_vld <= 1'b0;
                r_rd_vld <= 1'b0;
                r_wr_pld <= '0;
                r_rd_pld <= '0;
            end else begin
                r_wr_vld <= w_wr_grant;
                r_rd_vld <= w_rd_grant;
                if (w_wr_grant) begin
                    r_wr_pld <= w_wr_pld;
                end
                if (w_rd_grant) begin
                    r_rd_pld <= west_rd_pld[g];
                end
                // Counter only advances while a write is waiting behind a read; it stops at the limit
                if (w_wr_grant) begin
                    r_ptr <= w_next_ptr;
                    r_cnt <= '0;
                end else if (w_rd_grant && w_any_wr) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

        assign west_wr_rdy[g]            = w_gnt[0];
        assign north_wr_rdy[g]           = w_gnt[1];
        assign south_wr_rdy[g]           = w_gnt[2];
        assign west_rd_rdy[g]            = w_rd_grant;
        assign starve_evt[g]             = w_wr_grant && w_force;
        assign east_write_cmd_out_vld[g] = r_wr_vld;
        assign east_write_cmd_out_pld[g] = r_wr_pld;
        assign east_read_cmd_out_vld[g]  = r_rd_vld;
        assign east_read_cmd_out_pld[g]  = r_rd_pld;
    end

endmodule

// File: tb/tb_xy_diag_write_arb.sv
// tb/tb_xy_diag_write_arb.sv - self-checking bench for xy_diag_write_arb
module tb_xy_diag_write_arb;
    import vector_cache_pkg::*;

    localparam int CH  = 8;
    localparam int LIM = 4;

    logic                    clk;
    logic                    rst;
    logic           [CH-1:0] west_wr_vld;
    write_ram_cmd_t [CH-1:0] west_wr_pld;
    logic           [CH-1:0] west_wr_rdy;
    logic           [CH-1:0] north_wr_vld;
    write_ram_cmd_t [CH-1:0] north_wr_pld;
    logic           [CH-1:0] north_wr_rdy;
    logic           [CH-1:0] south_wr_vld;
    write_ram_cmd_t [CH-1:0] south_wr_pld;
    logic           [CH-1:0] south_wr_rdy;
    logic           [CH-1:0] west_rd_vld;
    arb_out_req_t   [CH-1:0] west_rd_pld;
    logic           [CH-1:0] west_rd_rdy;
    logic           [CH-1:0] east_write_cmd_out_vld;
    write_ram_cmd_t [CH-1:0] east_write_cmd_out_pld;
    logic           [CH-1:0] east_read_cmd_out_vld;
    arb_out_req_t   [CH-1:0] east_read_cmd_out_pld;
    logic           [CH-1:0] starve_evt;

    int n_checks;
    int n_errors;

    xy_diag_write_arb #(
        .CH_NUM       (CH),
        .STARVE_LIMIT (LIM),
        .CNT_W        (3)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .west_wr_vld            (west_wr_vld),
        .west_wr_pld            (west_wr_pld),
        .west_wr_rdy            (west_wr_rdy),
        .north_wr_vld           (north_wr_vld),
        .north_wr_pld           (north_wr_pld),
        .north_wr_rdy           (north_wr_rdy),
        .south_wr_vld           (south_wr_vld),
        .south_wr_pld           (south_wr_pld),
        .south_wr_rdy           (south_wr_rdy),
        .west_rd_vld            (west_rd_vld),
        .west_rd_pld            (west_rd_pld),
        .west_rd_rdy            (west_rd_rdy),
        .east_write_cmd_out_vld (east_write_cmd_out_vld),
        .east_write_cmd_out_pld (east_write_cmd_out_pld),
        .east_read_cmd_out_vld  (east_read_cmd_out_vld),
        .east_read_cmd_out_pld  (east_read_cmd_out_pld),
        .starve_evt             (starve_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        west_wr_vld  = '0;
        north_wr_vld = '0;
        south_wr_vld = '0;
        west_rd_vld  = '0;
        west_wr_pld  = '0;
        north_wr_pld = '0;
        south_wr_pld = '0;
        west_rd_pld  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        west_wr_vld = '1;
        west_rd_vld = '1;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({west_wr_rdy, north_wr_rdy, south_wr_rdy, west_rd_rdy} !== '0) begin
            n_errors++;
            $display("FAIL reset_rdy: got %h want 0", {west_wr_rdy, north_wr_rdy, south_wr_rdy, west_rd_rdy});
        end
        n_checks++;
        if ({east_write_cmd_out_vld, east_read_cmd_out_vld, starve_evt} !== '0) begin
            n_errors++;
            $display("FAIL reset_vld: got %h want 0", {east_write_cmd_out_vld, east_read_cmd_out_vld, starve_evt});
        end
        n_checks++;
        if (east_write_cmd_out_pld !== '0 || east_read_cmd_out_pld !== '0) begin
            n_errors++;
            $display("FAIL reset_pld: got %h / %h want 0", east_write_cmd_out_pld, east_read_cmd_out_pld);
        end
        tick();
        rst = 1'b0;
        clear_inputs();
        tick();
    endtask

    task automatic test_single_write();
        clear_inputs();
        west_wr_vld[0] = 1'b1;
        west_wr_pld[0] = '{addr: 16'h0010, data: 32'hDEAD_0010};
        @(negedge clk);
        n_checks++;
        if (west_wr_rdy !== 8'h01 || north_wr_rdy !== '0 || south_wr_rdy !== '0 || west_rd_rdy !== '0) begin
            n_errors++;
            $display("FAIL single_rdy: got w=%h n=%h s=%h r=%h want w=01", west_wr_rdy, north_wr_rdy, south_wr_rdy, west_rd_rdy);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (east_write_cmd_out_vld !== 8'h01 || east_read_cmd_out_vld !== '0) begin
            n_errors++;
            $display("FAIL single_out_vld: got wr=%h rd=%h want wr=01 rd=00", east_write_cmd_out_vld, east_read_cmd_out_vld);
        end
        n_checks++;
        if (east_write_cmd_out_pld[0].addr !== 16'h0010 || east_write_cmd_out_pld[0].data !== 32'hDEAD_0010) begin
            n_errors++;
            $display("FAIL single_out_pld: got %h want 0010dead0010", east_write_cmd_out_pld[0]);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (east_write_cmd_out_vld !== '0) begin
            n_errors++;
            $display("FAIL single_out_clear: got %h want 00", east_write_cmd_out_vld);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int seq [6] = '{0, 1, 2, 0, 1, 2};
        logic [2:0] got;
        clear_inputs();
        west_wr_vld[3]  = 1'b1;
        north_wr_vld[3] = 1'b1;
        south_wr_vld[3] = 1'b1;
        west_wr_pld[3]  = '{addr: 16'h0300, data: 32'h3000_0000};
        north_wr_pld[3] = '{addr: 16'h0301, data: 32'h3000_0001};
        south_wr_pld[3] = '{addr: 16'h0302, data: 32'h3000_0002};
        for (int c = 0; c <= 6; c++) begin
            if (c == 6) clear_inputs();
            @(negedge clk);
            if (c < 6) begin
                got = {south_wr_rdy[3], north_wr_rdy[3], west_wr_rdy[3]};
                n_checks++;
                if (got !== (3'b001 << seq[c])) begin
                    n_errors++;
                    $display("FAIL rr_grant c%0d: got %b want %b", c, got, 3'b001 << seq[c]);
                end
            end
            if (c > 0) begin
                n_checks++;
                if (east_write_cmd_out_vld !== 8'h08 ||
                    east_write_cmd_out_pld[3].addr !== 16'h0300 + 16'(seq[c-1])) begin
                    n_errors++;
                    $display("FAIL rr_out c%0d: got vld=%h addr=%h want vld=08 addr=%h", c,
                             east_write_cmd_out_vld, east_write_cmd_out_pld[3].addr, 16'h0300 + 16'(seq[c-1]));
                end
            end
            tick();
        end
    endtask

    task automatic test_starvation();
        bit exp_w;
        bit prev_w;
        clear_inputs();
        west_rd_vld[1]  = 1'b1;
        west_rd_pld[1]  = '{addr: 16'h0100, id: 8'h11};
        north_wr_vld[1] = 1'b1;
        north_wr_pld[1] = '{addr: 16'h0111, data: 32'h0000_0111};
        prev_w = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) clear_inputs();
            exp_w = (c == 4 || c == 9);
            @(negedge clk);
            if (c < 10) begin
                n_checks++;
                if (west_rd_rdy[1] !== !exp_w || north_wr_rdy[1] !== exp_w || starve_evt !== (8'(exp_w) << 1)) begin
                    n_errors++;
                    $display("FAIL starve_c%0d: got rd=%b nw=%b evt=%h want rd=%b nw=%b", c,
                             west_rd_rdy[1], north_wr_rdy[1], starve_evt, !exp_w, exp_w);
                end
            end
            if (c > 0) begin
                n_checks++;
                if (east_write_cmd_out_vld !== (8'(prev_w) << 1) || east_read_cmd_out_vld !== (8'(!prev_w) << 1)) begin
                    n_errors++;
                    $display("FAIL starve_out c%0d: got wr=%h rd=%h prev_write=%b", c,
                             east_write_cmd_out_vld, east_read_cmd_out_vld, prev_w);
                end
            end
            prev_w = exp_w;
            tick();
        end
    endtask

    task automatic test_reset_collision();
        clear_inputs();
        rst = 1'b1;
        south_wr_vld[2] = 1'b1;
        south_wr_pld[2] = '{addr: 16'h0222, data: 32'h2222_0002};
        @(negedge clk);
        n_checks++;
        if (south_wr_rdy !== '0) begin
            n_errors++;
            $display("FAIL rstcol_rdy: got %h want 00", south_wr_rdy);
        end
        tick();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (east_write_cmd_out_vld !== '0 || east_read_cmd_out_vld !== '0 || starve_evt !== '0 ||
            east_write_cmd_out_pld !== '0 || east_read_cmd_out_pld !== '0) begin
            n_errors++;
            $display("FAIL rstcol_out: got wr=%h rd=%h evt=%h pld=%h want all 0",
                     east_write_cmd_out_vld, east_read_cmd_out_vld, starve_evt, east_write_cmd_out_pld);
        end
        tick();
        south_wr_vld[2] = 1'b1;
        south_wr_pld[2] = '{addr: 16'h0222, data: 32'h2222_0002};
        @(negedge clk);
        n_checks++;
        if (south_wr_rdy !== 8'h04 || west_wr_rdy !== '0 || north_wr_rdy !== '0) begin
            n_errors++;
            $display("FAIL rstcol_regrant: got s=%h want 04", south_wr_rdy);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (east_write_cmd_out_vld !== 8'h04 || east_write_cmd_out_pld[2].addr !== 16'h0222) begin
            n_errors++;
            $display("FAIL rstcol_out2: got vld=%h addr=%h want vld=04 addr=0222",
                     east_write_cmd_out_vld, east_write_cmd_out_pld[2].addr);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        write_ram_cmd_t cur [CH];
        write_ram_cmd_t prev [CH];
        int             pulses [CH];
        logic [CH-1:0]  ew, en, es;
        int             src;
        for (int ch = 0; ch < CH; ch++) pulses[ch] = 0;
        for (int c = 0; c <= 16; c++) begin
            clear_inputs();
            ew = '0; en = '0; es = '0;
            if (c < 16) begin
                for (int ch = 0; ch < CH; ch++) begin
                    src = int'($urandom_range(0, 2));
                    cur[ch] = '{addr: 16'(ch * 256 + c), data: $urandom};
                    case (src)
                        0: begin west_wr_vld[ch]  = 1'b1; west_wr_pld[ch]  = cur[ch]; ew[ch] = 1'b1; end
                        1: begin north_wr_vld[ch] = 1'b1; north_wr_pld[ch] = cur[ch]; en[ch] = 1'b1; end
                        default: begin south_wr_vld[ch] = 1'b1; south_wr_pld[ch] = cur[ch]; es[ch] = 1'b1; end
                    endcase
                end
            end
            @(negedge clk);
            if (c < 16) begin
                n_checks++;
                if ({west_wr_rdy, north_wr_rdy, south_wr_rdy} !== {ew, en, es}) begin
                    n_errors++;
                    $display("FAIL b2b_rdy c%0d: got %h want %h", c,
                             {west_wr_rdy, north_wr_rdy, south_wr_rdy}, {ew, en, es});
                end
            end
            if (c > 0) begin
                for (int ch = 0; ch < CH; ch++) begin
                    if (east_write_cmd_out_vld[ch] === 1'b1) pulses[ch]++;
                    n_checks++;
                    if (east_write_cmd_out_vld[ch] !== 1'b1 || east_write_cmd_out_pld[ch] !== prev[ch]) begin
                        n_errors++;
                        $display("FAIL b2b_out c%0d ch%0d: got vld=%b pld=%h want vld=1 pld=%h", c, ch,
                                 east_write_cmd_out_vld[ch], east_write_cmd_out_pld[ch], prev[ch]);
                    end
                end
            end
            prev = cur;
            tick();
        end
        for (int ch = 0; ch < CH; ch++) begin
            n_checks++;
            if (pulses[ch] != 16) begin
                n_errors++;
                $display("FAIL b2b_count ch%0d: got %0d want 16", ch, pulses[ch]);
            end
        end
    endtask

    // Reference: each requester holds its command until granted; slot rules applied per channel
    task automatic test_random();
        bit             pend [CH][4];
        write_ram_cmd_t wp [CH][3];
        arb_out_req_t   rp [CH];
        int             m_ptr [CH];
        int             m_cnt [CH];
        int             g_cur [CH];
        int             g_prev [CH];
        bit             evt [CH];
        write_ram_cmd_t pw_prev [CH];
        arb_out_req_t   pr_prev [CH];
        logic [CH-1:0]  xw, xn, xs, xr, xe, xow, xor_;
        bit             wr_any, rd;
        int             s, nrdy;
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        for (int ch = 0; ch < CH; ch++) begin
            m_ptr[ch] = 0; m_cnt[ch] = 0; g_prev[ch] = -1;
            for (int k = 0; k < 4; k++) pend[ch][k] = 0;
        end
        for (int c = 0; c <= 100; c++) begin
            for (int ch = 0; ch < CH; ch++) begin
                for (int k = 0; k < 4; k++) begin
                    if (c < 100 && !pend[ch][k] && $urandom_range(0, 3) != 0) begin
                        pend[ch][k] = 1;
                        if (k < 3) wp[ch][k] = '{addr: 16'($urandom), data: $urandom};
                        else       rp[ch]    = '{addr: 16'($urandom), id: 8'($urandom)};
                    end
                end
                west_wr_vld[ch]  = pend[ch][0]; west_wr_pld[ch]  = wp[ch][0];
                north_wr_vld[ch] = pend[ch][1]; north_wr_pld[ch] = wp[ch][1];
                south_wr_vld[ch] = pend[ch][2]; south_wr_pld[ch] = wp[ch][2];
                west_rd_vld[ch]  = pend[ch][3]; west_rd_pld[ch]  = rp[ch];

                wr_any = pend[ch][0] | pend[ch][1] | pend[ch][2];
                rd     = pend[ch][3];
                g_cur[ch] = -1;
                evt[ch]   = 0;
                if (!wr_any) begin
                    if (rd) g_cur[ch] = 3;
                end else if (!rd || m_cnt[ch] == LIM) begin
                    evt[ch] = rd;
                    for (int k = 0; k < 3; k++) begin
                        s = (m_ptr[ch] + k) % 3;
                        if (g_cur[ch] < 0 && pend[ch][s]) g_cur[ch] = s;
                    end
                    m_ptr[ch] = (g_cur[ch] + 1) % 3;
                    m_cnt[ch] = 0;
                end else begin
                    g_cur[ch] = 3;
                    m_cnt[ch]++;
                end
                xw[ch] = (g_cur[ch] == 0); xn[ch] = (g_cur[ch] == 1);
                xs[ch] = (g_cur[ch] == 2); xr[ch] = (g_cur[ch] == 3);
                xe[ch] = evt[ch];
                xow[ch] = (g_prev[ch] >= 0 && g_prev[ch] < 3);
                xor_[ch] = (g_prev[ch] == 3);
            end
            @(negedge clk);
            n_checks++;
            if ({west_wr_rdy, north_wr_rdy, south_wr_rdy, west_rd_rdy, starve_evt} !== {xw, xn, xs, xr, xe}) begin
                n_errors++;
                $display("FAIL rand_rdy c%0d: got %h want %h", c,
                         {west_wr_rdy, north_wr_rdy, south_wr_rdy, west_rd_rdy, starve_evt}, {xw, xn, xs, xr, xe});
            end
            nrdy = 0;
            for (int ch = 0; ch < CH; ch++) begin
                if ((int'(west_wr_rdy[ch]) + int'(north_wr_rdy[ch]) + int'(south_wr_rdy[ch]) + int'(west_rd_rdy[ch])) > 1)
                    nrdy++;
            end
            n_checks++;
            if (nrdy != 0 || (east_write_cmd_out_vld & east_read_cmd_out_vld) !== '0) begin
                n_errors++;
                $display("FAIL rand_excl c%0d: got %0d multi-rdy channels, overlap %h want none", c, nrdy,
                         east_write_cmd_out_vld & east_read_cmd_out_vld);
            end
            n_checks++;
            if (east_write_cmd_out_vld !== xow || east_read_cmd_out_vld !== xor_) begin
                n_errors++;
                $display("FAIL rand_vld c%0d: got wr=%h rd=%h want wr=%h rd=%h", c,
                         east_write_cmd_out_vld, east_read_cmd_out_vld, xow, xor_);
            end
            for (int ch = 0; ch < CH; ch++) begin
                if (xow[ch]) begin
                    n_checks++;
                    if (east_write_cmd_out_pld[ch] !== pw_prev[ch]) begin
                        n_errors++;
                        $display("FAIL rand_wpld c%0d ch%0d: got %h want %h", c, ch, east_write_cmd_out_pld[ch], pw_prev[ch]);
                    end
                end
                if (xor_[ch]) begin
                    n_checks++;
                    if (east_read_cmd_out_pld[ch] !== pr_prev[ch]) begin
                        n_errors++;
                        $display("FAIL rand_rpld c%0d ch%0d: got %h want %h", c, ch, east_read_cmd_out_pld[ch], pr_prev[ch]);
                    end
                end
            end
            tick();
            for (int ch = 0; ch < CH; ch++) begin
                g_prev[ch] = g_cur[ch];
                if (g_cur[ch] >= 0 && g_cur[ch] < 3) pw_prev[ch] = wp[ch][g_cur[ch]];
                if (g_cur[ch] == 3) pr_prev[ch] = rp[ch];
                if (g_cur[ch] >= 0) pend[ch][g_cur[ch]] = 0;
            end
        end
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_starvation();
        test_reset_collision();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
